// File: rtl/gshare_predictor_pkg.sv
// gshare_predictor_pkg
// Shared definitions for the sail-core gshare branch predictor:
// 2-bit counter encodings, counter reset value and default table geometry.
// No ports (package).
package gshare_predictor_pkg;

  // 2-bit saturating counter states; bit 1 is the taken prediction.
  localparam logic [1:0] kSAIL_BHT_SNT = 2'b00;  // strong not-taken
  localparam logic [1:0] kSAIL_BHT_WNT = 2'b01;  // weak not-taken
  localparam logic [1:0] kSAIL_BHT_WT  = 2'b10;  // weak taken
  localparam logic [1:0] kSAIL_BHT_ST  = 2'b11;  // strong taken

  // Counters start weakly not-taken so one taken outcome flips the prediction.
  localparam logic [1:0] kSAIL_BHT_RESET = kSAIL_BHT_WNT;

  localparam int kSAIL_INDEX_BITS = 6;
  localparam int kSAIL_HIST_BITS  = 4;

endpackage

// File: rtl/gshare_predictor_if.sv
// gshare_predictor_if
// Lookup/update/status bundle between the pipeline and the predictor.
//   lookup : lkp_valid, lkp_pc, lkp_offset -> lkp_taken, lkp_target, lkp_idx
//   update : upd_valid, upd_idx, upd_taken, upd_predicted
//   status : mispredict, ghr, mispredict_count
// master = pipeline side, slave = predictor side.
interface gshare_predictor_if #(
  parameter int INDEX_BITS = 6,
  parameter int HIST_BITS  = 4
);
  logic                  lkp_valid;
  logic [31:0]           lkp_pc;
  logic [31:0]           lkp_offset;
  logic                  lkp_taken;
  logic [31:0]           lkp_target;
  logic [INDEX_BITS-1:0] lkp_idx;

  logic                  upd_valid;
  logic [INDEX_BITS-1:0] upd_idx;
  logic                  upd_taken;
  logic                  upd_predicted;

  logic                  mispredict;
  logic [HIST_BITS-1:0]  ghr;
  logic [31:0]           mispredict_count;

  modport master (
    output lkp_valid, lkp_pc, lkp_offset,
    input  lkp_taken, lkp_target, lkp_idx,
    output upd_valid, upd_idx, upd_taken, upd_predicted,
    input  mispredict, ghr, mispredict_count
  );

  modport slave (
    input  lkp_valid, lkp_pc, lkp_offset,
    output lkp_taken, lkp_target, lkp_idx,
    input  upd_valid, upd_idx, upd_taken, upd_predicted,
    output mispredict, ghr, mispredict_count
  );
endinterface

// File: rtl/gshare_predictor_sat2_next.sv
// sat2_next
// Combinational next state of a 2-bit saturating counter.
//   cur   in  2  current counter value
//   taken in  1  resolved outcome (1 = count up, 0 = count down)
//   nxt   out 2  next counter value, clamped at 00 and 11
module sat2_next
  import gshare_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != kSAIL_BHT_ST) nxt = cur + 2'd1;
    end else begin
      if (cur != kSAIL_BHT_SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor
// gshare conditional-branch predictor: table of 2-bit counters indexed by
// PC[INDEX_BITS+1:2] XOR global history. Trains only on resolved branches.
//   clk  in  core clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave modport of gshare_predictor_if (lookup, update, status)
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int INDEX_BITS = kSAIL_INDEX_BITS,
  parameter int HIST_BITS  = kSAIL_HIST_BITS
) (
  input  logic               clk,
  input  logic               rst,
  gshare_predictor_if.slave  bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            tbl [ENTRIES];
  logic [HIST_BITS-1:0]  ghr_q;
  logic [HIST_BITS-1:0]  ghr_nxt;
  logic                  mispredict_q;
  logic [31:0]           count_q;
  logic [INDEX_BITS-1:0] lkp_idx;
  logic [1:0]            upd_cur;
  logic [1:0]            upd_nxt;
  logic                  upd_miss;

  // Lookup path: purely combinational, reads pre-update table and history.
  assign lkp_idx        = bus.lkp_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
  assign bus.lkp_idx    = lkp_idx;
  assign bus.lkp_taken  = bus.lkp_valid & tbl[lkp_idx][1];
  assign bus.lkp_target = bus.lkp_pc + bus.lkp_offset;

  assign upd_cur  = tbl[bus.upd_idx];
  assign upd_miss = bus.upd_predicted ^ bus.upd_taken;

  sat2_next u_sat2_next (
    .cur   (upd_cur),
    .taken (bus.upd_taken),
    .nxt   (upd_nxt)
  );

  generate
    if (HIST_BITS == 1) begin : g_ghr_one
      assign ghr_nxt = bus.upd_taken;
    end else begin : g_ghr_shift
      assign ghr_nxt = {ghr_q[HIST_BITS-2:0], bus.upd_taken};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= kSAIL_BHT_RESET;
      ghr_q        <= '0;
      mispredict_q <= 1'b0;
      count_q      <= '0;
    end else begin
      mispredict_q <= bus.upd_valid & upd_miss;
      if (bus.upd_valid) begin
        tbl[bus.upd_idx] <= upd_nxt;
        ghr_q            <= ghr_nxt;
        if (upd_miss && (count_q != 32'hFFFF_FFFF)) count_q <= count_q + 32'd1;
      end
    end
  end

  assign bus.ghr              = ghr_q;
  assign bus.mispredict       = mispredict_q;
  assign bus.mispredict_count = count_q;

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

  localparam int IB = 6;
  localparam int HB = 4;

  logic clk;
  logic rst;

  gshare_predictor_if #(.INDEX_BITS(IB), .HIST_BITS(HB)) bus ();

  gshare_predictor #(.INDEX_BITS(IB), .HIST_BITS(HB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %0h expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    expect_val(tag, exp);
    compare(obs);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lkp(input logic v, input logic [31:0] pc, input logic [31:0] off);
    bus.lkp_valid  = v;
    bus.lkp_pc     = pc;
    bus.lkp_offset = off;
  endtask

  task automatic set_upd(input logic v, input logic [IB-1:0] idx, input logic tk, input logic pr);
    bus.upd_valid     = v;
    bus.upd_idx       = idx;
    bus.upd_taken     = tk;
    bus.upd_predicted = pr;
  endtask

  initial begin
    rst = 1'b1;
    set_lkp(1'b0, 32'h0, 32'h0);
    set_upd(1'b0, '0, 1'b0, 1'b0);
    #12;
    chk("rst_ghr", 32'(bus.ghr), 32'h0);
    chk("rst_mispredict", 32'(bus.mispredict), 32'h0);
    chk("rst_count", bus.mispredict_count, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic lookup and target arithmetic.
    set_lkp(1'b1, 32'h100, 32'h20);
    #1;
    chk("lkp_idx_0x100", 32'(bus.lkp_idx), 32'h0);
    chk("lkp_taken_0x100", 32'(bus.lkp_taken), 32'h0);
    chk("lkp_target_0x100", bus.lkp_target, 32'h120);
    set_lkp(1'b0, 32'h100, 32'h20);
    #1;
    chk("lkp_taken_invalid", 32'(bus.lkp_taken), 32'h0);
    set_lkp(1'b1, 32'h1000, 32'hFFFF_FFF0);
    #1;
    chk("lkp_target_neg", bus.lkp_target, 32'h0000_0FF0);
    set_lkp(1'b1, 32'hFFFF_FFFC, 32'h8);
    #1;
    chk("lkp_target_wrap", bus.lkp_target, 32'h4);
    for (int i = 0; i < 64; i++) begin
      set_lkp(1'b1, 32'(i) << 2, 32'h0);
      #1;
      chk("post_rst_taken", 32'(bus.lkp_taken), 32'h0);
    end

    // Two back-to-back taken mispredicts on idx 5.
    set_lkp(1'b0, 32'h0, 32'h0);
    set_upd(1'b1, 6'd5, 1'b1, 1'b0);
    step();
    chk("b2b_mp1", 32'(bus.mispredict), 32'h1);
    chk("b2b_cnt1", bus.mispredict_count, 32'h1);
    chk("b2b_ghr1", 32'(bus.ghr), 32'h1);
    step();
    chk("b2b_mp2", 32'(bus.mispredict), 32'h1);
    chk("b2b_cnt2", bus.mispredict_count, 32'h2);
    chk("b2b_ghr2", 32'(bus.ghr), 32'h3);
    set_upd(1'b0, 6'd0, 1'b0, 1'b0);
    set_lkp(1'b1, 32'h18, 32'h0);
    #1;
    chk("idx5_idx", 32'(bus.lkp_idx), 32'h5);
    chk("idx5_taken", 32'(bus.lkp_taken), 32'h1);
    step();
    chk("idle_mp", 32'(bus.mispredict), 32'h0);
    chk("idle_cnt", bus.mispredict_count, 32'h2);

    // Saturation on idx 9.
    set_lkp(1'b0, 32'h0, 32'h0);
    set_upd(1'b1, 6'd9, 1'b1, 1'b1);
    repeat (4) step();
    chk("sat_up_mp", 32'(bus.mispredict), 32'h0);
    chk("sat_up_cnt", bus.mispredict_count, 32'h2);
    chk("sat_up_ghr", 32'(bus.ghr), 32'hF);
    set_upd(1'b1, 6'd9, 1'b0, 1'b0);
    step();
    chk("sat_dn1_ghr", 32'(bus.ghr), 32'hE);
    set_upd(1'b0, 6'd0, 1'b0, 1'b0);
    set_lkp(1'b1, 32'h1C, 32'h0);
    #1;
    chk("sat_dn1_idx", 32'(bus.lkp_idx), 32'h9);
    chk("sat_dn1_taken", 32'(bus.lkp_taken), 32'h1);
    set_upd(1'b1, 6'd9, 1'b0, 1'b0);
    repeat (4) step();
    set_upd(1'b0, 6'd0, 1'b0, 1'b0);
    chk("sat_dn5_ghr", 32'(bus.ghr), 32'h0);
    set_lkp(1'b1, 32'h24, 32'h0);
    #1;
    chk("sat_dn5_idx", 32'(bus.lkp_idx), 32'h9);
    chk("sat_dn5_taken", 32'(bus.lkp_taken), 32'h0);
    // From 00 one taken step reaches 01 (not taken); a wrap to 11 or a stuck 01 would read taken.
    set_upd(1'b1, 6'd9, 1'b1, 1'b1);
    step();
    set_upd(1'b0, 6'd0, 1'b0, 1'b0);
    chk("sat_floor_ghr", 32'(bus.ghr), 32'h1);
    set_lkp(1'b1, 32'h20, 32'h0);
    #1;
    chk("sat_floor_idx", 32'(bus.lkp_idx), 32'h9);
    chk("sat_floor_taken", 32'(bus.lkp_taken), 32'h0);

    // Single mispredict pulse, then a correct prediction.
    set_lkp(1'b0, 32'h0, 32'h0);
    set_upd(1'b1, 6'd20, 1'b0, 1'b1);
    step();
    set_upd(1'b0, 6'd0, 1'b0, 1'b0);
    chk("mp_pulse", 32'(bus.mispredict), 32'h1);
    chk("mp_cnt", bus.mispredict_count, 32'h3);
    chk("mp_ghr", 32'(bus.ghr), 32'h2);
    step();
    chk("mp_drop", 32'(bus.mispredict), 32'h0);
    chk("mp_drop_cnt", bus.mispredict_count, 32'h3);
    set_upd(1'b1, 6'd20, 1'b1, 1'b1);
    step();
    set_upd(1'b0, 6'd0, 1'b0, 1'b0);
    chk("match_mp", 32'(bus.mispredict), 32'h0);
    chk("match_cnt", bus.mispredict_count, 32'h3);
    chk("match_ghr", 32'(bus.ghr), 32'h5);

    // Same-cycle lookup and update to idx 3: no bypass.
    set_lkp(1'b1, 32'h18, 32'h0);
    set_upd(1'b1, 6'd3, 1'b1, 1'b0);
    #1;
    chk("same_idx", 32'(bus.lkp_idx), 32'h3);
    chk("same_old_taken", 32'(bus.lkp_taken), 32'h0);
    step();
    set_upd(1'b0, 6'd0, 1'b0, 1'b0);
    chk("same_ghr", 32'(bus.ghr), 32'hB);
    chk("same_mp", 32'(bus.mispredict), 32'h1);
    chk("same_cnt", bus.mispredict_count, 32'h4);
    set_lkp(1'b1, 32'h20, 32'h0);
    #1;
    chk("same_new_idx", 32'(bus.lkp_idx), 32'h3);
    chk("same_new_taken", 32'(bus.lkp_taken), 32'h1);

    // Asynchronous reset between edges with an update pending.
    set_upd(1'b1, 6'd5, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_ghr", 32'(bus.ghr), 32'h0);
    chk("arst_mp", 32'(bus.mispredict), 32'h0);
    chk("arst_cnt", bus.mispredict_count, 32'h0);
    step();
    chk("arst_edge_ghr", 32'(bus.ghr), 32'h0);
    chk("arst_edge_mp", 32'(bus.mispredict), 32'h0);
    chk("arst_edge_cnt", bus.mispredict_count, 32'h0);
    for (int i = 0; i < 64; i++) begin
      set_lkp(1'b1, 32'(i) << 2, 32'h0);
      #1;
      chk("arst_taken", 32'(bus.lkp_taken), 32'h0);
    end
    set_upd(1'b0, 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    set_upd(1'b1, 6'd7, 1'b1, 1'b1);
    step();
    set_upd(1'b0, 6'd0, 1'b0, 1'b0);
    chk("post_arst_ghr", 32'(bus.ghr), 32'h1);
    chk("post_arst_mp", 32'(bus.mispredict), 32'h0);
    chk("post_arst_cnt", bus.mispredict_count, 32'h0);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Dynamic conditional-branch predictor for the sail-core pipeline: a gshare table of 2-bit saturating counters indexed by PC XOR global history. It consumes the ALU's resolved branch decision (Branch_Enable) from execute and supplies a taken/not-taken prediction plus target address to fetch/decode. The table trains on resolution only, so history stays non-speculative. Mispredictions are counted for performance analysis.

## Interface
- INDEX_BITS, 6: log2 of table entries (64 counters).
- HIST_BITS, 4: global history length; legal range 1..INDEX_BITS.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- lkp_valid  in  1  decode stage holds a conditional branch.
- lkp_pc  in  32  PC of that branch.
- lkp_offset  in  32  sign-extended B-type immediate.
- lkp_taken  out  1  prediction; 0 whenever lkp_valid=0.
- lkp_target  out  32  lkp_pc + lkp_offset, modulo 2^32.
- lkp_idx  out  INDEX_BITS  table index used; the pipeline carries it to execute.
- upd_valid  in  1  execute stage resolved a conditional branch this cycle.
- upd_idx  in  INDEX_BITS  lkp_idx carried with that branch.
- upd_taken  in  1  actual outcome (ALU Branch_Enable).
- upd_predicted  in  1  lkp_taken carried with that branch.
- mispredict  out  1  registered one-cycle pulse on mismatch.
- ghr  out  HIST_BITS  current global history register.
- mispredict_count  out  32  saturating mispredict total.

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is bit 1.
- lkp_idx = lkp_pc[INDEX_BITS+1:2] XOR zero-extended ghr.
- Lookup is combinational: lkp_taken = lkp_valid & table[lkp_idx][1].
- On upd_valid, table[upd_idx] updates:
  - taken: increment, saturating at 11.
  - not taken: decrement, saturating at 00.
- On upd_valid, ghr <= {ghr[HIST_BITS-2:0], upd_taken}. When HIST_BITS=1, ghr <= upd_taken.
- On upd_valid with upd_predicted != upd_taken:
  - mispredict <= 1.
  - mispredict_count increments, holding at 0xFFFFFFFF.
- Otherwise mispredict <= 0.
- When upd_valid=0, no table, ghr or count change occurs, and upd_* inputs are ignored.
- Reset state: all counters 01, ghr 0, mispredict 0, mispredict_count 0. The table is flops, not BRAM, so it clears on reset. After reset, lkp_taken is 0 for every index.

## Timing
- Lookup latency is 0 cycles; lkp_taken, lkp_target and lkp_idx are purely combinational.
- An update becomes visible to lookups one cycle after the upd_valid edge.
- Same-cycle lookup and update to the same index: the lookup sees the old counter (no bypass). Lookup also uses the pre-update ghr.
- mispredict asserts exactly one cycle after the resolving upd_valid edge and lasts one cycle, unless the next update also mispredicts.
- Back-to-back upd_valid on consecutive cycles is legal; each update applies in order.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. Updates presented while rst=1 are lost. The first edge after deassertion behaves normally.

## Structure
- sail-core-defines gains:
  - counter encodings kSAIL_BHT_SNT/WNT/WT/ST.
  - reset counter value kSAIL_BHT_RESET = WNT.
  - default INDEX_BITS/HIST_BITS.
- One sub-module, sat2_next: combinational 2-bit saturating next-state (inputs cur[1:0], taken; output nxt[1:0]). Instantiated once, on the upd_idx entry.
- Top module holds the table array, ghr, mispredict flop, count register, lookup mux and target adder.

## Test plan
- Reset, then lookup with lkp_valid=1, lkp_pc=0x100, lkp_offset=0x20 -> lkp_idx=0, lkp_taken=0, lkp_target=0x120. Repeat with lkp_valid=0 -> lkp_taken=0.
- Two updates to idx 5, taken=1, predicted=0 -> counter 11 after the second edge. A lookup with lkp_idx=5 gives lkp_taken=1. ghr=4'b0011. mispredict pulses on both cycles, then count=2.
- Saturation: four taken updates on idx 9, then one not-taken -> counter 10, lookup idx 9 still taken. Four more not-taken -> counter 00 with no wrap to 11.
- Mispredict: update predicted=1, taken=0 -> mispredict=1 on the next cycle only, count increments by 1. A matching update (predicted=taken=1) leaves mispredict=0 and count unchanged.
- Same cycle, lookup idx 3 (counter 01) and taken update to idx 3 -> lkp_taken=0 that cycle, 1 on the next lookup.
- Assert rst between edges after training -> ghr, mispredict and count read 0 before the next edge. All lookups predict not-taken, and a pending upd_valid during reset has no effect.
